keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16: clock cycles each column is driven (dwell), minimum 4.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 1000: consecutive stable cycles needed to accept a press or a release, minimum 2.
REQ-003 SHALL have parameter REPEAT_DLY, default 50000: cycles between auto-repeat pulses, used only when KEYPAD_REPEAT_EN is defined.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clock and rst_n.
REQ-005 clock  input  1  rising-edge system clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 row_in  input  4  keypad rows, active-low, asynchronous to clock.
REQ-008 col_out  output  4  column drive, active-low one-hot.
REQ-009 col_idx  output  2  index of the driven column (0..3).
REQ-010 key_code  output  4  hex code of the last accepted key.
REQ-011 key_valid  output  1  one-cycle pulse when key_code is updated or repeated.
REQ-012 key_held  output  1  high while an accepted key is still down.

Function
REQ-013 row_in SHALL pass through a 2-flop synchronizer (reset 4'b1111); all decisions use the synchronized value rs.
REQ-014 col_out SHALL equal ~(4'b0001 << col_idx) at all times.
REQ-015 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-016 SCAN: a dwell counter SHALL count 0..SCAN_DIV-1; on the last dwell cycle, if rs has exactly one zero bit the FSM SHALL latch rs, freeze col_idx and enter DEBOUNCE; otherwise col_idx SHALL increment mod 4 (3 wraps to 0).
REQ-017 SCAN: rs of 4'b1111 or rs with two or more zero bits SHALL be treated as no key.
REQ-018 DEBOUNCE: the debounce counter SHALL increment on each cycle rs equals the latched pattern; any mismatch SHALL return the FSM to SCAN with col_idx advanced by one.
REQ-019 DEBOUNCE: when DEBOUNCE_CNT matching cycles are reached, the FSM SHALL enter PRESSED, update key_code, pulse key_valid in that same cycle, and set key_held.
REQ-020 key_code mapping for (col_idx, rs), rs = 1110/1101/1011/0111: col0 -> 1/5/9/D; col1 -> 2/6/A/E; col2 -> 3/7/B/F; col3 -> 4/8/C/0.
REQ-021 PRESSED: the FSM SHALL stay while rs != 4'b1111 and SHALL enter RELEASE when rs == 4'b1111.
REQ-022 RELEASE: DEBOUNCE_CNT consecutive 4'b1111 cycles SHALL clear key_held and return the FSM to SCAN with col_idx advanced; any non-1111 cycle SHALL restart the count and return the FSM to PRESSED.
REQ-023 key_code SHALL hold its value until the next accepted press.
REQ-024 key_valid SHALL never be high on two consecutive cycles.

Reset
REQ-025 On rst_n low, asynchronously: state=SCAN, col_idx=0, col_out=4'b1110, key_code=4'h0, key_valid=0, key_held=0, all counters=0, synchronizer=4'b1111.
REQ-026 Reset asserted mid-DEBOUNCE or mid-PRESSED SHALL abort with no key_valid pulse; after release, scanning SHALL restart at column 0.

Configuration
REQ-027 Macro KEYPAD_REPEAT_EN: when defined, in PRESSED a repeat counter SHALL pulse key_valid (key_code unchanged) every REPEAT_DLY cycles after acceptance, with the counter cleared when PRESSED is entered.
REQ-028 When KEYPAD_REPEAT_EN is undefined, the repeat counter SHALL be absent and exactly one key_valid pulse SHALL occur per press.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_DLY=32)
REQ-029 Idle after reset, rows 1111 -> col_idx cycles 0,1,2,3,0 every 4 clocks; key_valid stays 0.
REQ-030 row_in=1011 asserted only while col_idx=2, held 20 cycles -> key_code=4'hB, exactly one key_valid pulse, key_held=1 until 8 cycles after release.
REQ-031 Bounce: row_in=1101 on col 3 for 5 cycles then 1111 -> no key_valid; scanning resumes at column 0.
REQ-032 Two rows low (1100) on col 1 -> treated as no key; scan continues with no key_valid.
REQ-033 With KEYPAD_REPEAT_EN defined, key 0 (col 3, 0111) held 100 cycles after acceptance -> key_valid pulses at acceptance and at +32, +64 and +96 cycles; undefined -> exactly 1 pulse.
REQ-034 rst_n pulsed low during PRESSED -> all outputs return to reset values immediately; no key_valid is produced.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with a row synchronizer,
// press/release debounce and hex key encoding.
// Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat pulses on key_valid
// while a key is held. The default build has no repeat logic.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 1000,
    parameter int REPEAT_DLY   = 50000
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [1:0] col_idx,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CNT - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DLY < 2) begin : g_param_check
        $error("keypad_scan_ctrl: parameter below its minimum");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q, rs_q;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [DIV_W-1:0] dwell_q, dwell_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       latch_q, latch_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DLY);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DLY - 1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    // Exactly one row pulled low means a single unambiguous key.
    function automatic logic single_zero(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
    endfunction

    // Keypad legend: columns 0..3 across, rows 0..3 down, bottom-right is 0.
    function automatic logic [3:0] key_map(input logic [1:0] col, input logic [3:0] r);
        logic [3:0] code;
        case ({col, r})
            6'b00_1110: code = 4'h1;
            6'b00_1101: code = 4'h5;
            6'b00_1011: code = 4'h9;
            6'b00_0111: code = 4'hD;
            6'b01_1110: code = 4'h2;
            6'b01_1101: code = 4'h6;
            6'b01_1011: code = 4'hA;
            6'b01_0111: code = 4'hE;
            6'b10_1110: code = 4'h3;
            6'b10_1101: code = 4'h7;
            6'b10_1011: code = 4'hB;
            6'b10_0111: code = 4'hF;
            6'b11_1110: code = 4'h4;
            6'b11_1101: code = 4'h8;
            6'b11_1011: code = 4'hC;
            default:    code = 4'h0;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous row lines (idle high).
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b1111;
            rs_q    <= 4'b1111;
        end else begin
            sync1_q <= row_in;
            rs_q    <= sync1_q;
        end
    end

    // Next-state logic: scan columns, debounce press, hold, debounce release.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        latch_d     = latch_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (single_zero(rs_q)) begin
                        latch_d = rs_q;
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rs_q == latch_q) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d       = '0;
                        state_d     = PRESSED;
                        key_code_d  = key_map(col_idx_q, latch_q);
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_d       = '0;
`endif
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    // Bounce: give up on this column and move on.
                    deb_d     = '0;
                    dwell_d   = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end
            end
            PRESSED: begin
                if (rs_q == 4'b1111) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_q == REP_LAST) begin
                    rep_d       = '0;
                    key_valid_d = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (rs_q == 4'b1111) begin
                    if (deb_q == DEB_LAST) begin
                        deb_d      = '0;
                        dwell_d    = '0;
                        key_held_d = 1'b0;
                        col_idx_d  = col_idx_q + 2'd1;
                        state_d    = SCAN;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    deb_d   = '0;
                    state_d = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                    rep_d   = '0;
`endif
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            latch_q     <= 4'b1111;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            latch_q     <= latch_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign col_out   = ~(4'b0001 << col_idx_q);
    assign col_idx   = col_idx_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model drives row_in from the
// driven column; expectations come from the keypad legend and timing rules.
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DC = 8;
    localparam int RD = 32;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [1:0] col_idx;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int checks = 0;
    int errors = 0;

    // Keypad model: a held key pulls its row low only while its column is driven.
    logic       kp_down   = 1'b0;
    logic [1:0] kp_col    = 2'd0;
    logic [1:0] kp_row    = 2'd0;
    logic       kp_direct = 1'b0;
    logic [3:0] kp_val    = 4'hF;
    logic [3:0] onehot_n [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [3:0] last_code = 4'h0;

    always_comb begin
        row_in = 4'hF;
        if (kp_direct) row_in = kp_val;
        else if (kp_down && col_out == onehot_n[kp_col]) row_in = onehot_n[kp_row];
    end

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .REPEAT_DLY(RD)) dut (
        .clock(clock), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
        .col_idx(col_idx), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clock = ~clock;

    // Keypad legend: code = column + 4*row + 1, modulo 16.
    function automatic logic [3:0] exp_code(input int c, input int r);
        int v;
        v = (c + 4 * r + 1) % 16;
        return 4'(v);
    endfunction

    task automatic check_reset_outputs(input string name);
        checks++;
        if (col_idx !== 2'd0 || col_out !== 4'hE || key_code !== 4'h0 ||
            key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL %s: col_idx=%0d col_out=%b key_code=%h key_valid=%b key_held=%b required 0 1110 0 0 0",
                     name, col_idx, col_out, key_code, key_valid, key_held);
        end
    endtask

    task automatic check_scan_from_zero(input int n, input string name);
        int bad;
        bad = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            checks++;
            if (col_idx !== 2'((k / SD) % 4) || col_out !== onehot_n[(k / SD) % 4] ||
                key_valid !== 1'b0 || key_held !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d: col_idx=%0d col_out=%b valid=%b held=%b required col %0d valid 0 held 0",
                         name, k, col_idx, col_out, key_valid, key_held, (k / SD) % 4);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        check_scan_from_zero(20, "idle_scan");
    endtask

    task automatic run_press(input logic [1:0] c, input logic [1:0] r, input int hold, input string name);
        logic got;
        logic [3:0] want;
        int q[$];
        int e[$];
        int rel_j;
        int extra;
        logic [1:0] col_at;
        logic [1:0] nxt;
        want = exp_code(int'(c), int'(r));
        nxt = c + 2'd1;
        kp_col = c; kp_row = r; kp_down = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 120 && !got; i++) begin
            @(negedge clock);
            if (key_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s accept: key_valid=0 required 1 within 120 cycles", name);
            kp_down = 1'b0;
            repeat (20) @(negedge clock);
            return;
        end
        checks++;
        if (key_code !== want) begin
            errors++;
            $display("FAIL %s code: key_code=%h required %h", name, key_code, want);
        end
        checks++;
        if (key_held !== 1'b1) begin
            errors++;
            $display("FAIL %s held_on_accept: key_held=%b required 1", name, key_held);
        end
        for (int i = 1; i <= hold; i++) begin
            @(negedge clock);
            if (key_valid === 1'b1) q.push_back(i);
        end
`ifdef KEYPAD_REPEAT_EN
        for (int t = RD; t <= hold; t += RD) e.push_back(t);
`endif
        checks++;
        if (q.size() != e.size()) begin
            errors++;
            $display("FAIL %s repeat_count: pulses=%0d required %0d", name, q.size(), e.size());
        end else begin
            for (int i = 0; i < q.size(); i++) begin
                checks++;
                if (q[i] != e[i]) begin
                    errors++;
                    $display("FAIL %s repeat_offset: offset=%0d required %0d", name, q[i], e[i]);
                end
            end
        end
        checks++;
        if (key_held !== 1'b1 || key_code !== want) begin
            errors++;
            $display("FAIL %s while_held: key_held=%b key_code=%h required 1 %h", name, key_held, key_code, want);
        end
        kp_down = 1'b0;
        rel_j = 0;
        extra = 0;
        col_at = 2'd0;
        for (int j = 1; j <= 20 && rel_j == 0; j++) begin
            @(negedge clock);
            if (key_valid === 1'b1) extra++;
            if (key_held === 1'b0) begin
                rel_j = j;
                col_at = col_idx;
            end
        end
        checks++;
        if (rel_j < DC || rel_j > DC + 4) begin
            errors++;
            $display("FAIL %s release_time: key_held fell after %0d cycles required %0d..%0d", name, rel_j, DC, DC + 4);
        end
        checks++;
        if (col_at !== nxt) begin
            errors++;
            $display("FAIL %s release_col: col_idx=%0d required %0d", name, col_at, nxt);
        end
        checks++;
        if (key_code !== want || extra != 0) begin
            errors++;
            $display("FAIL %s after_release: key_code=%h extra_pulses=%0d required %h 0", name, key_code, extra, want);
        end
        last_code = want;
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_col_entry(input logic [1:0] c, output logic ok);
        logic [1:0] prev;
        prev = col_idx;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            if (col_idx == c && prev != c) ok = 1'b1;
            prev = col_idx;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_col: column %0d not reached within 60 cycles", c);
        end
    endtask

    task automatic test_bounce();
        logic ok;
        int run;
        int pulses;
        logic [1:0] after;
        logic done;
        wait_col_entry(2'd3, ok);
        if (!ok) return;
        kp_direct = 1'b1; kp_val = 4'b1101;
        run = 1; pulses = 0; done = 1'b0; after = 2'd3;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 5) kp_val = 4'hF;
            if (key_valid === 1'b1) pulses++;
            if (!done) begin
                if (col_idx == 2'd3) run++;
                else begin
                    done = 1'b1;
                    after = col_idx;
                end
            end
        end
        kp_direct = 1'b0;
        checks++;
        if (pulses != 0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL bounce_no_key: pulses=%0d key_held=%b required 0 0", pulses, key_held);
        end
        checks++;
        if (run <= SD || run > SD + DC) begin
            errors++;
            $display("FAIL bounce_freeze: column 3 held %0d cycles required %0d..%0d", run, SD + 1, SD + DC);
        end
        checks++;
        if (!done || after !== 2'd0) begin
            errors++;
            $display("FAIL bounce_resume: next column=%0d required 0", after);
        end
    endtask

    task automatic test_two_rows();
        logic ok;
        int run;
        int pulses;
        logic [1:0] after;
        logic done;
        wait_col_entry(2'd1, ok);
        if (!ok) return;
        kp_direct = 1'b1; kp_val = 4'b1100;
        run = 1; pulses = 0; done = 1'b0; after = 2'd1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (key_valid === 1'b1) pulses++;
            if (!done) begin
                if (col_idx == 2'd1) run++;
                else begin
                    done = 1'b1;
                    after = col_idx;
                end
            end
        end
        kp_direct = 1'b0;
        checks++;
        if (pulses != 0 || key_held !== 1'b0 || key_code !== last_code) begin
            errors++;
            $display("FAIL two_rows_no_key: pulses=%0d held=%b code=%h required 0 0 %h", pulses, key_held, key_code, last_code);
        end
        checks++;
        if (run != SD || after !== 2'd2) begin
            errors++;
            $display("FAIL two_rows_scan: column 1 held %0d cycles then %0d required %0d then 2", run, after, SD);
        end
    endtask

    task automatic test_random_keys();
        logic [1:0] c;
        logic [1:0] r;
        for (int n = 0; n < 6; n++) begin
            c = 2'($urandom_range(0, 3));
            r = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 12)) @(negedge clock);
            run_press(c, r, $urandom_range(1, 25), $sformatf("random_key%0d", n));
        end
    endtask

    task automatic test_reset_debounce();
        int pulses;
        rst_n = 1'b0;
        kp_col = 2'd0; kp_row = 2'd0; kp_down = 1'b1;
        @(negedge clock);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clock);
            if (key_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || key_held !== 1'b0 || col_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_debounce_pre: pulses=%0d held=%b col=%0d required 0 0 0", pulses, key_held, col_idx);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_debounce_async");
        kp_down = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        check_scan_from_zero(24, "reset_debounce_after");
    endtask

    task automatic test_reset_pressed();
        logic got;
        kp_col = 2'd2; kp_row = 2'd1; kp_down = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 120 && !got; i++) begin
            @(negedge clock);
            if (key_valid === 1'b1) got = 1'b1;
        end
        repeat (3) @(negedge clock);
        checks++;
        if (!got || key_held !== 1'b1 || key_code !== exp_code(2, 1)) begin
            errors++;
            $display("FAIL reset_pressed_pre: accepted=%b held=%b code=%h required 1 1 %h", got, key_held, key_code, exp_code(2, 1));
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_pressed_async");
        kp_down = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_outputs("reset_pressed_hold");
        rst_n = 1'b1;
        check_scan_from_zero(24, "reset_pressed_after");
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        run_press(2'd2, 2'd2, 20, "key_B");
        test_bounce();
        test_two_rows();
        run_press(2'd3, 2'd3, 100, "key_0_repeat");
        test_random_keys();
        test_reset_debounce();
        test_reset_pressed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
